// File: rtl/fb_game_pkg.sv
// Shared types for the fireboy/icegirl game control blocks.
// Game state encoding and player count used across the top-level FSMs.
package fb_game_pkg;

  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    DYING     = 3'd1,
    FADE      = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4,
    RESTART   = 3'd5
  } game_state_t;

  localparam int PLAYER_COUNT = 2;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the restart key.
// Only arms once the key has been seen released while enabled.
module key_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic key,
  output logic rise
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = key;
    armed_d = en & (armed_q | ~key);
  end

  assign rise = en & armed_q & key & ~prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/death_sequencer.sv
// End-of-life / level-complete sequencer: freeze, blink, fade,
// overlay, then a timed level_reset pulse back into PLAY.
module death_sequencer
  import fb_game_pkg::*;
#(
  parameter int DYING_FRAMES = 60,
  parameter int BLINK_PERIOD = 8,
  parameter int FADE_STEP    = 4,
  parameter int RESET_CYCLES = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic                    player1_dead,
  input  logic                    player2_dead,
  input  logic                    level_done,
  input  logic                    restart_key,
  output logic                    freeze_players,
  output logic [PLAYER_COUNT-1:0] dead_mask,
  output logic                    dead_blink_on,
  output logic [3:0]              fade_level,
  output logic                    show_game_over,
  output logic                    show_win,
  output logic                    level_reset,
  output logic [2:0]              game_state
);

  localparam int DW = cnt_w(DYING_FRAMES);
  localparam int BW = cnt_w(BLINK_PERIOD);
  localparam int FW = cnt_w(FADE_STEP);
  localparam int RW = cnt_w(RESET_CYCLES);

  localparam logic [DW-1:0] DMAX = DW'(DYING_FRAMES - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_PERIOD - 1);
  localparam logic [FW-1:0] FMAX = FW'(FADE_STEP - 1);
  localparam logic [RW-1:0] RMAX = RW'(RESET_CYCLES - 1);

  game_state_t state_q, state_d;

  logic [PLAYER_COUNT-1:0] mask_q, mask_d;
  logic                    blink_q, blink_d;
  logic [3:0]              fade_q, fade_d;
  logic                    freeze_q, freeze_d;
  logic                    go_q, go_d;
  logic                    win_q, win_d;
  logic                    lr_q, lr_d;

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  logic [PLAYER_COUNT-1:0] dead_in;
  logic                    wait_st;
  logic                    key_rise;

  assign dead_in = {player2_dead, player1_dead};
  assign wait_st = (state_q == GAME_OVER) || (state_q == WIN);

  key_edge_detect u_key (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (wait_st),
    .key   (restart_key),
    .rise  (key_rise)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    blink_d = blink_q;
    fade_d  = fade_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;

    unique case (state_q)
      PLAY: begin
        if (|dead_in) begin
          state_d = DYING;
          mask_d  = dead_in;
        end else if (level_done) begin
          state_d = WIN;
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (dcnt_q == DMAX) state_d = FADE;
          else dcnt_d = dcnt_q + DW'(1);
          if (bcnt_q == BMAX) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      FADE: begin
        if (fade_q == 4'hF) begin
          state_d = GAME_OVER;
        end else if (frame_tick) begin
          if (fcnt_q == FMAX) begin
            fcnt_d = '0;
            fade_d = fade_q + 4'd1;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      GAME_OVER: if (key_rise) state_d = RESTART;
      WIN:       if (key_rise) state_d = RESTART;
      RESTART: begin
        if (rcnt_q == RMAX) state_d = PLAY;
        else rcnt_d = rcnt_q + RW'(1);
      end
      default: state_d = PLAY;
    endcase

    // Entry into DYING is caused by a dead flag, so a coincident tick
    // is a fresh tick for the new state; FADE entry consumes its tick.
    if (state_d != state_q) begin
      dcnt_d = '0;
      bcnt_d = '0;
      fcnt_d = '0;
      rcnt_d = '0;
      if (state_d == DYING) begin
        dcnt_d = DW'(frame_tick);
        bcnt_d = BW'(frame_tick);
      end
    end

    if (state_d != DYING) blink_d = 1'b1;

    unique case (state_d)
      PLAY: begin
        mask_d = '0;
        fade_d = '0;
      end
      WIN:       fade_d = '0;
      GAME_OVER: fade_d = 4'hF;
      default: ;
    endcase

    freeze_d = (state_d != PLAY);
    go_d     = (state_d == GAME_OVER);
    win_d    = (state_d == WIN);
    lr_d     = (state_d == RESTART);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= PLAY;
      mask_q   <= '0;
      blink_q  <= 1'b1;
      fade_q   <= '0;
      freeze_q <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      lr_q     <= 1'b0;
      dcnt_q   <= '0;
      bcnt_q   <= '0;
      fcnt_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      blink_q  <= blink_d;
      fade_q   <= fade_d;
      freeze_q <= freeze_d;
      go_q     <= go_d;
      win_q    <= win_d;
      lr_q     <= lr_d;
      dcnt_q   <= dcnt_d;
      bcnt_q   <= bcnt_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign freeze_players = freeze_q;
  assign dead_mask      = mask_q;
  assign dead_blink_on  = blink_q;
  assign fade_level     = fade_q;
  assign show_game_over = go_q;
  assign show_win       = win_q;
  assign level_reset    = lr_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_death_sequencer.sv
// Directed bench for death_sequencer: PLAY decode table plus
// hand-written blink/fade/restart/reset sequences.
module tb_death_sequencer;
  import fb_game_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       player1_dead;
  logic       player2_dead;
  logic       level_done;
  logic       restart_key;
  logic       freeze_players;
  logic [1:0] dead_mask;
  logic       dead_blink_on;
  logic [3:0] fade_level;
  logic       show_game_over;
  logic       show_win;
  logic       level_reset;
  logic [2:0] game_state;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  death_sequencer dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_tick     (frame_tick),
    .player1_dead   (player1_dead),
    .player2_dead   (player2_dead),
    .level_done     (level_done),
    .restart_key    (restart_key),
    .freeze_players (freeze_players),
    .dead_mask      (dead_mask),
    .dead_blink_on  (dead_blink_on),
    .fade_level     (fade_level),
    .show_game_over (show_game_over),
    .show_win       (show_win),
    .level_reset    (level_reset),
    .game_state     (game_state)
  );

  typedef struct {
    logic       p1;
    logic       p2;
    logic       done;
    logic [2:0] st;
    logic [1:0] mask;
    logic       frz;
    logic       win;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset        = 1'b1;
    frame_tick   = 1'b0;
    player1_dead = 1'b0;
    player2_dead = 1'b0;
    level_done   = 1'b0;
    restart_key  = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 8'(game_state), 8'(PLAY));
    chk({tag, "_freeze"}, 8'(freeze_players), 8'd0);
    chk({tag, "_mask"}, 8'(dead_mask), 8'd0);
    chk({tag, "_blink"}, 8'(dead_blink_on), 8'd1);
    chk({tag, "_fade"}, 8'(fade_level), 8'd0);
    chk({tag, "_go"}, 8'(show_game_over), 8'd0);
    chk({tag, "_win"}, 8'(show_win), 8'd0);
    chk({tag, "_lreset"}, 8'(level_reset), 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lr_cnt;

    vt[0] = '{1'b0, 1'b0, 1'b0, PLAY,  2'b00, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, DYING, 2'b01, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, DYING, 2'b10, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, DYING, 2'b11, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, WIN,   2'b00, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, DYING, 2'b10, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, DYING, 2'b11, 1'b1, 1'b0};

    do_reset();
    chk_reset_vals("rst");

    for (int i = 0; i < 7; i++) begin
      do_reset();
      player1_dead = vt[i].p1;
      player2_dead = vt[i].p2;
      level_done   = vt[i].done;
      step();
      player1_dead = 1'b0;
      player2_dead = 1'b0;
      level_done   = 1'b0;
      chk($sformatf("v%0d_state", i), 8'(game_state), 8'(vt[i].st));
      chk($sformatf("v%0d_mask", i), 8'(dead_mask), 8'(vt[i].mask));
      chk($sformatf("v%0d_freeze", i), 8'(freeze_players), 8'(vt[i].frz));
      chk($sformatf("v%0d_win", i), 8'(show_win), 8'(vt[i].win));
      chk($sformatf("v%0d_fade", i), 8'(fade_level), 8'd0);
    end

    // Full death run with sticky flag, fade, held key, restart.
    do_reset();
    player1_dead = 1'b1;
    step();
    chk("d_state", 8'(game_state), 8'(DYING));
    chk("d_blink0", 8'(dead_blink_on), 8'd1);
    tick(7);
    chk("d_blink7", 8'(dead_blink_on), 8'd1);
    tick(1);
    chk("d_blink8", 8'(dead_blink_on), 8'd0);
    tick(8);
    chk("d_blink16", 8'(dead_blink_on), 8'd1);
    tick(43);
    chk("d_state59", 8'(game_state), 8'(DYING));
    chk("d_blink59", 8'(dead_blink_on), 8'd0);
    chk("d_mask59", 8'(dead_mask), 8'b01);
    tick(1);
    chk("f_state", 8'(game_state), 8'(FADE));
    chk("f_blink", 8'(dead_blink_on), 8'd1);
    tick(3);
    chk("f_fade3", 8'(fade_level), 8'd0);
    tick(1);
    chk("f_fade4", 8'(fade_level), 8'd1);
    tick(55);
    chk("f_fade59", 8'(fade_level), 8'd14);
    tick(1);
    chk("f_fade60", 8'(fade_level), 8'd15);
    chk("f_state60", 8'(game_state), 8'(FADE));
    restart_key = 1'b1;
    step();
    chk("go_state", 8'(game_state), 8'(GAME_OVER));
    chk("go_show", 8'(show_game_over), 8'd1);
    chk("go_fade", 8'(fade_level), 8'd15);
    repeat (3) step();
    chk("go_held", 8'(game_state), 8'(GAME_OVER));
    restart_key = 1'b0;
    step();
    chk("go_rel", 8'(game_state), 8'(GAME_OVER));
    restart_key = 1'b1;
    step();
    restart_key = 1'b0;
    chk("rs_state", 8'(game_state), 8'(RESTART));
    chk("rs_go", 8'(show_game_over), 8'd0);
    chk("rs_freeze", 8'(freeze_players), 8'd1);
    lr_cnt = (level_reset === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (level_reset === 1'b1) lr_cnt++;
      else break;
    end
    player1_dead = 1'b0;
    chk("rs_len", 8'(lr_cnt), 8'd4);
    chk("rs_play", 8'(game_state), 8'(PLAY));
    chk("rs_fade", 8'(fade_level), 8'd0);
    chk("rs_mask", 8'(dead_mask), 8'd0);
    chk("rs_freeze0", 8'(freeze_players), 8'd0);
    step();
    chk("rs_stay", 8'(game_state), 8'(PLAY));

    // WIN ignores deaths, key edge restarts.
    do_reset();
    level_done = 1'b1;
    step();
    level_done   = 1'b0;
    player2_dead = 1'b1;
    step();
    chk("w_ign", 8'(game_state), 8'(WIN));
    chk("w_mask", 8'(dead_mask), 8'd0);
    player2_dead = 1'b0;
    restart_key  = 1'b1;
    step();
    restart_key = 1'b0;
    chk("w_rs", 8'(game_state), 8'(RESTART));
    chk("w_lr", 8'(level_reset), 8'd1);
    chk("w_show", 8'(show_win), 8'd0);

    // Tick on DYING entry counts; reset mid-fade.
    do_reset();
    player2_dead = 1'b1;
    frame_tick   = 1'b1;
    step();
    player2_dead = 1'b0;
    tick(6);
    chk("e_blink7", 8'(dead_blink_on), 8'd1);
    tick(1);
    chk("e_blink8", 8'(dead_blink_on), 8'd0);
    tick(52);
    chk("e_state60", 8'(game_state), 8'(FADE));
    tick(28);
    chk("e_fade7", 8'(fade_level), 8'd7);
    Reset        = 1'b1;
    frame_tick   = 1'b1;
    player1_dead = 1'b1;
    step();
    Reset        = 1'b0;
    frame_tick   = 1'b0;
    player1_dead = 1'b0;
    chk_reset_vals("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
